// File: rtl/lane_merge_rr_pkg.sv
`default_nettype none
// ============================================================================
// Package   : lane_pkg
// Purpose   : Shared constants and types for the two-lane merge datapath.
// Revision  : 1.0 - initial release
// ============================================================================
package lane_pkg;

    localparam int LANE_WIDTH = 4;
    localparam int FIFO_DEPTH = 2;

    localparam logic SRC_RIGHT = 1'b0;
    localparam logic SRC_LEFT  = 1'b1;

    // The arbiter state mirrors whether the output register holds a word.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    // A lane FIFO can take a word only while it is below its depth.
    function automatic logic fifo_has_room(input logic [1:0] count);
        return count < 2'(FIFO_DEPTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_merge_rr_if.sv
`default_nettype none
// ============================================================================
// Interface : lane_merge_rr_if
// Purpose   : Right/left input streams and merged output stream of the
//             round-robin lane merge.
// Revision  : 1.0 - initial release
// ============================================================================
interface lane_merge_rr_if
    import lane_pkg::*;
#(
    parameter int WIDTH = LANE_WIDTH
);

    logic [WIDTH-1:0] right_data;
    logic             right_valid;
    logic             right_ready;

    logic [WIDTH-1:0] left_data;
    logic             left_valid;
    logic             left_ready;

    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_valid;
    logic             out_ready;

    // Traffic source / sink side (drives the lanes, consumes the output).
    modport master (
        output right_data, right_valid, left_data, left_valid, out_ready,
        input  right_ready, left_ready, out_data, out_src, out_valid
    );

    // Merge unit side.
    modport slave (
        input  right_data, right_valid, left_data, left_valid, out_ready,
        output right_ready, left_ready, out_data, out_src, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/lane_merge_rr_fifo.sv
`default_nettype none
// ============================================================================
// Module    : lane_fifo
// Purpose   : Two-entry in-order lane buffer. Ready depends only on the
//             current count, so a full FIFO refuses a push even when it is
//             popped in the same cycle.
// Revision  : 1.0 - initial release
// ============================================================================
module lane_fifo
    import lane_pkg::*;
#(
    parameter int WIDTH = LANE_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  ready
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push_ok;
    logic             pop_ok;

    assign ready   = fifo_has_room(count);
    assign empty   = (count == 2'd0);
    assign push_ok = push && ready;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at 1 -> 0; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_merge_rr.sv
`default_nettype none
// ============================================================================
// Module    : lane_merge_rr
// Purpose   : Round-robin merge of right/left lane streams into one
//             registered, source-tagged output stream.
// Revision  : 1.0 - initial release
// ============================================================================
module lane_merge_rr
    import lane_pkg::*;
#(
    parameter int WIDTH = LANE_WIDTH
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    lane_merge_rr_if.slave bus
);

    logic [WIDTH-1:0] right_dout;
    logic [WIDTH-1:0] left_dout;
    logic             right_empty;
    logic             left_empty;
    logic             load;
    logic             grant_right;
    logic             grant_left;
    logic             any_grant;

    arb_state_t       state;
    logic             prio;
    logic [WIDTH-1:0] data_q;
    logic             src_q;

    lane_fifo #(.WIDTH(WIDTH)) u_right_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.right_valid),
        .din   (bus.right_data),
        .pop   (grant_right),
        .dout  (right_dout),
        .empty (right_empty),
        .ready (bus.right_ready)
    );

    lane_fifo #(.WIDTH(WIDTH)) u_left_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.left_valid),
        .din   (bus.left_data),
        .pop   (grant_left),
        .dout  (left_dout),
        .empty (left_empty),
        .ready (bus.left_ready)
    );

    // The output register may take a new word when empty or being drained.
    assign load = (state == EMPTY) || bus.out_ready;

    // A lone non-empty lane wins outright; on contention prio decides.
    assign grant_right = load && !right_empty && (left_empty  || (prio == SRC_RIGHT));
    assign grant_left  = load && !left_empty  && (right_empty || (prio == SRC_LEFT));
    assign any_grant   = grant_right || grant_left;

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;

    // Arbiter FSM: loads the granted head, flips priority, tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            prio   <= SRC_RIGHT;
            data_q <= '0;
            src_q  <= SRC_RIGHT;
        end else begin
            case (state)
                EMPTY: begin
                    if (any_grant) begin
                        data_q <= grant_left ? left_dout : right_dout;
                        src_q  <= grant_left ? SRC_LEFT : SRC_RIGHT;
                        prio   <= grant_left ? SRC_RIGHT : SRC_LEFT;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    // Stalled output keeps data, tag and priority untouched.
                    if (bus.out_ready) begin
                        if (any_grant) begin
                            data_q <= grant_left ? left_dout : right_dout;
                            src_q  <= grant_left ? SRC_LEFT : SRC_RIGHT;
                            prio   <= grant_left ? SRC_RIGHT : SRC_LEFT;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_merge_rr.sv
`default_nettype none
// ============================================================================
// Module    : tb_lane_merge_rr
// Purpose   : Directed, table-driven bench for lane_merge_rr.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_lane_merge_rr;

    logic clk;
    logic rst_n;

    lane_merge_rr_if #(.WIDTH(4)) lm_if ();

    lane_merge_rr #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [3:0] rd;
        logic       lv;
        logic [3:0] ld;
        logic       ordy;
        logic       e_ov;
        logic [3:0] e_od;
        logic       e_os;
        logic       e_rr;
        logic       e_lr;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    task automatic add(input logic rv, input logic [3:0] rd, input logic lv,
                       input logic [3:0] ld, input logic ordy, input logic e_ov,
                       input logic [3:0] e_od, input logic e_os, input logic e_rr,
                       input logic e_lr);
        vec_t v;
        v.rv = rv; v.rd = rd; v.lv = lv; v.ld = ld; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os; v.e_rr = e_rr; v.e_lr = e_lr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic ov, input logic [3:0] od,
                              input logic os, input logic rr, input logic lr);
        check("out_valid",   idx, {3'b0, lm_if.out_valid},   {3'b0, ov});
        check("out_data",    idx, lm_if.out_data,            od);
        check("out_src",     idx, {3'b0, lm_if.out_src},     {3'b0, os});
        check("right_ready", idx, {3'b0, lm_if.right_ready}, {3'b0, rr});
        check("left_ready",  idx, {3'b0, lm_if.left_ready},  {3'b0, lr});
    endtask

    task automatic drive(input logic rv, input logic [3:0] rd, input logic lv,
                         input logic [3:0] ld, input logic ordy);
        lm_if.right_valid = rv;
        lm_if.right_data  = rd;
        lm_if.left_valid  = lv;
        lm_if.left_data   = ld;
        lm_if.out_ready   = ordy;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Each row: inputs for one edge, expected outputs just after it.
        //   rv rd     lv ld     ordy | ov od     os rr lr
        // contention: R gets 1,2 and L gets 9,8 -> (1,R)(9,L)(2,R)(8,L)
        add(1, 4'h1, 1, 4'h9, 1,  0, 4'h0, 0, 1, 1);
        add(1, 4'h2, 1, 4'h8, 1,  1, 4'h1, 0, 1, 0);
        add(0, 4'h0, 0, 4'h0, 1,  1, 4'h9, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  1, 4'h2, 0, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  1, 4'h8, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  0, 4'h8, 1, 1, 1);
        // single push A on right: visible two edges later, then drains
        add(1, 4'hA, 0, 4'h0, 1,  0, 4'h8, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  1, 4'hA, 0, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  0, 4'hA, 0, 1, 1);
        // backpressure on left with out_ready low, then full FIFO + pop
        add(0, 4'h0, 1, 4'h3, 0,  0, 4'hA, 0, 1, 1);
        add(0, 4'h0, 1, 4'h4, 0,  1, 4'h3, 1, 1, 1);
        add(0, 4'h0, 1, 4'h5, 0,  1, 4'h3, 1, 1, 0);
        add(0, 4'h0, 1, 4'h6, 0,  1, 4'h3, 1, 1, 0);
        add(0, 4'h0, 1, 4'h6, 1,  1, 4'h4, 1, 1, 1);
        add(0, 4'h0, 1, 4'h6, 1,  1, 4'h5, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  1, 4'h6, 1, 1, 1);
        // left was granted last; idle five cycles, then both push
        add(0, 4'h0, 0, 4'h0, 1,  0, 4'h6, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  0, 4'h6, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  0, 4'h6, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  0, 4'h6, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  0, 4'h6, 1, 1, 1);
        add(1, 4'h7, 1, 4'hC, 1,  0, 4'h6, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  1, 4'h7, 0, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  1, 4'hC, 1, 1, 1);
        add(0, 4'h0, 0, 4'h0, 1,  0, 4'hC, 1, 1, 1);

        // Reset state while rst_n is held low.
        #12;
        check_outs(-1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rv, vecs[i].rd, vecs[i].lv, vecs[i].ld, vecs[i].ordy);
            @(posedge clk);
            #1;
            check_outs(i, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_os,
                       vecs[i].e_rr, vecs[i].e_lr);
        end

        // Mid-stream reset: fill both FIFOs behind a stalled output word.
        @(negedge clk); drive(1'b1, 4'h1, 1'b1, 4'h2, 1'b0);
        @(negedge clk); drive(1'b1, 4'h3, 1'b1, 4'h4, 1'b0);
        @(negedge clk); drive(1'b1, 4'h5, 1'b1, 4'h6, 1'b0);
        @(negedge clk); drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        check_outs(100, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_outs(101, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        @(posedge clk);
        #1 check_outs(102, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);

        // After reset only freshly pushed traffic may appear.
        @(negedge clk); drive(1'b1, 4'hB, 1'b0, 4'h0, 1'b1);
        @(negedge clk); drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        @(posedge clk);
        #1 check_outs(103, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1 check_outs(104, 1'b0, 4'hB, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_merge_rr.md
# lane_merge_rr

Two-lane round-robin merge unit for the 4-bit lane datapath. It accepts independent valid/ready streams on the right and left lanes, buffers each in a 2-entry FIFO, and merges them onto one registered output stream. Every output word carries a source tag so downstream logic can recover the originating lane. It is the collecting end for traffic that the mux/demux steering stage distributes to right/left.

## Interface
- `WIDTH`, default 4: data width per lane.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `right_data`  in  WIDTH  right-lane word.
- `right_valid`  in  1  right word present.
- `right_ready`  out  1  right FIFO can accept.
- `left_data`  in  WIDTH  left-lane word.
- `left_valid`  in  1  left word present.
- `left_ready`  out  1  left FIFO can accept.
- `out_data`  out  WIDTH  merged word.
- `out_src`  out  1  source tag: 0 = right, 1 = left.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  downstream accepts.

## Operation
- Lane push: a transfer occurs on a rising edge with `x_valid && x_ready`. `x_ready = (count_x < 2)` is a function of the FIFO count only, not of a same-cycle pop. A full FIFO rejects the push even when it is popped in the same cycle.
- Each lane FIFO holds 2 entries and is in-order. It has a 1-bit write pointer, a 1-bit read pointer, and a 2-bit count. Pointers wrap 1→0.
- Output register load enable: `load = !out_valid || out_ready`.
- Arbitration when `load` is high:
  - If neither FIFO is non-empty, `out_valid` goes to 0 when `out_ready` is high. Otherwise the output holds.
  - If exactly one FIFO is non-empty, grant that FIFO.
  - If both FIFOs are non-empty, grant the lane selected by the priority pointer `prio` (0 = right).
- On a grant: pop the FIFO head into `out_data`, set `out_src` to the granted lane, set `out_valid` = 1, and set `prio` = opposite of the granted lane.
- The arbiter has two states:
  - EMPTY (`out_valid` = 0) → FULL on any grant.
  - FULL → FULL on a grant while `out_ready` is high.
  - FULL → EMPTY when `out_ready` is high and no FIFO is non-empty.
  - FULL holds while `out_ready` is low, with no pop and no `prio` change.
- A simultaneous push and pop on the same FIFO is legal when count < 2. Count is unchanged and the pointers both advance.
- No word is ever dropped or duplicated. Per-lane order is preserved.

## Timing
- Reset values, applied asynchronously: `out_valid` = 0, `out_data` = 0, `out_src` = 0, `prio` = 0, both FIFO counts and pointers = 0, so `right_ready` = `left_ready` = 1.
- Reset asserted mid-operation empties all state immediately. Buffered words are discarded.
- Latency: a word pushed at edge N is visible at the output after edge N+1 if the output is free (2-cycle min).
- Throughput: one output word per cycle while `out_ready` = 1 and any FIFO is non-empty. With both lanes loaded, output alternates R, L, R, L.
- `out_data` and `out_src` must be stable while `out_valid && !out_ready`.
- `x_ready` deasserts the cycle after count reaches 2. It reasserts the cycle after the first pop.

## Structure
- Shared package `lane_pkg`: `LANE_WIDTH` = 4, `FIFO_DEPTH` = 2, `SRC_RIGHT` = 1'b0, `SRC_LEFT` = 1'b1, and the arbiter state enum (EMPTY, FULL).
- Sub-module `lane_fifo` (parameter `WIDTH`) has ports `push`, `din`, `pop`, `dout`, `empty`, `ready`. It is instantiated twice.
- The top level contains the arbiter, `prio`, and the output register.

## Test plan
- Reset then single push: right_data=4'hA for one cycle with `out_ready`=1 → `out_valid`=1, `out_data`=A, `out_src`=0 two edges later. `out_valid` returns to 0 the next cycle.
- Contention: push right 1,2 and left 9,8 in the same two cycles with `out_ready`=1 → output sequence (1,R),(9,L),(2,R),(8,L) on consecutive cycles.
- Backpressure: hold `out_ready`=0 and push 3 words on left → `left_ready` drops after 2 pushes, the output holds the first word stable, and the third word is accepted once `out_ready`=1. Final order is preserved.
- Full FIFO with simultaneous pop: FIFO full, `out_ready`=1, `left_valid`=1 → push rejected that cycle and accepted the next. No loss.
- Priority persistence: grant left, leave both lanes idle 5 cycles, then both lanes push simultaneously → right is granted first (`prio`=0).
- Mid-stream reset: pulse `rst_n` low with both FIFOs full and `out_valid`=1 → all outputs are at reset values immediately, and both ready signals are 1 after release.
